prefetch_queue: RTL

- Parametrised successor to the single-word prefetch stage; sits between the IF stage and the icache/MMU path.
- Runs ahead of IF, keeping up to DEPTH 32-bit fetch words in flight or buffered.
- Extracts aligned 16/32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Supports redirect flush and fault propagation.

---
 rtl/pf_pkg.sv | 18 +
 rtl/pf_fifo.sv | 48 ++++
 rtl/prefetch_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pf_pkg.sv
// Shared types for the instruction prefetch queue: queue entry, request FSM
// states and the 32-bit opcode marker.
package pf_pkg;

   typedef struct packed {
      logic [31:0] data;
      logic        fault;
   } pf_entry_t;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_WAIT,
      PF_DROP
   } pf_state_e;

   localparam logic [1:0] OPCODE_32B = 2'b11;

endpackage

// File: rtl/pf_fifo.sv
// Circular word buffer for the prefetch queue; exposes head and head+1 so a
// straddling 32-bit instruction can be assembled without waiting for a pop.
module pf_fifo
   import pf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  pf_entry_t                  push_entry,
   input  logic                       pop,
   output pf_entry_t                  head,
   output pf_entry_t                  next,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   pf_entry_t         mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     cnt;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: occupancy is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head  = mem[rd_ptr];
   assign next  = mem[rd_ptr + AW'(1)];
   assign count = cnt;

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch queue between IF and the icache: runs ahead fetching words and
// extracts 16/32-bit instructions. Compressed support enabled by PF_RVC_EN.
module prefetch_queue
   import pf_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              ic_req_o,
   output logic [ADDR_W-1:0] ic_addr_o,
   input  logic              ic_ack_i,
   input  logic [31:0]       ic_rdata_i,
   input  logic              ic_fault_i,
   output logic              if_valid_o,
   output logic [31:0]       if_instr_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic              if_is_comp_o,
   output logic              if_fault_o,
   input  logic              if_ready_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   function automatic logic [ADDR_W-1:0] ipc_align(input logic [ADDR_W-1:0] pc);
`ifdef PF_RVC_EN
      return {pc[ADDR_W-1:1], 1'b0};
`else
      return {pc[ADDR_W-1:2], 2'b00};
`endif
   endfunction

   pf_state_e         state;
   logic              boot;
   logic              fault_lat;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] ipc;

   pf_entry_t         head;
   pf_entry_t         nxt;
   logic [CW-1:0]     count;

   logic              issue;
   logic              push;
   logic              pop;
   logic              cons;
   logic              h;
   logic              comp;
   logic [15:0]       lo16;

   // A redirect suppresses a fresh issue so no request is raised for a stale fpc.
   assign issue    = !rst && !boot && !redirect_i && (state == PF_IDLE) &&
                     !fault_lat && (count < CW'(DEPTH));
   assign ic_req_o = issue || (!rst && (state == PF_WAIT));
   assign ic_addr_o = fpc;
   assign push     = ic_ack_i && ic_req_o && !redirect_i;

   always_comb begin
      h            = 1'b0;
      comp         = 1'b0;
      lo16         = head.data[15:0];
      if_valid_o   = 1'b0;
      if_instr_o   = '0;
      if_is_comp_o = 1'b0;
      if_fault_o   = 1'b0;
`ifdef PF_RVC_EN
      h    = ipc[1];
      lo16 = h ? head.data[31:16] : head.data[15:0];
      comp = (lo16[1:0] != OPCODE_32B);
      if (!rst && count != '0)
         if_valid_o = comp || !h || (count >= CW'(2)) || head.fault;
      if (head.fault) begin
         if_fault_o = 1'b1;
      end else if (comp) begin
         if_instr_o   = {16'h0000, lo16};
         if_is_comp_o = 1'b1;
      end else if (h) begin
         if_fault_o = nxt.fault;
         if_instr_o = nxt.fault ? 32'h0 : {nxt.data[15:0], head.data[31:16]};
      end else begin
         if_instr_o = head.data;
      end
`else
      if_valid_o = !rst && (count != '0);
      if_fault_o = head.fault;
      if_instr_o = head.fault ? 32'h0 : head.data;
`endif
   end

   assign if_pc_o = ipc;
   assign cons    = if_valid_o && if_ready_i && !redirect_i;
`ifdef PF_RVC_EN
   assign pop     = cons && (h || !comp);
`else
   assign pop     = cons;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PF_IDLE;
         boot      <= 1'b1;
         fault_lat <= 1'b0;
         fpc       <= {RESET_PC[ADDR_W-1:2], 2'b00};
         ipc       <= ipc_align(RESET_PC);
      end else begin
         boot <= 1'b0;
         if (redirect_i) begin
            fault_lat <= 1'b0;
            fpc       <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            ipc       <= ipc_align(redirect_pc_i);
            // An in-flight request must still be absorbed before refetching.
            state     <= (state != PF_IDLE && !ic_ack_i) ? PF_DROP : PF_IDLE;
         end else begin
            case (state)
               PF_IDLE: if (issue && !ic_ack_i) state <= PF_WAIT;
               PF_WAIT: if (ic_ack_i) state <= PF_IDLE;
               PF_DROP: if (ic_ack_i) state <= PF_IDLE;
               default: state <= PF_IDLE;
            endcase
            if (push) begin
               fpc <= fpc + ADDR_W'(4);
               if (ic_fault_i) fault_lat <= 1'b1;
            end
            if (cons) ipc <= ipc + (comp ? ADDR_W'(2) : ADDR_W'(4));
         end
      end
   end

   pf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_i),
      .push       (push),
      .push_entry ('{data: ic_rdata_i, fault: ic_fault_i}),
      .pop        (pop),
      .head       (head),
      .next       (nxt),
      .count      (count)
   );

endmodule
